acc_regfile: RTL
================

Name: acc_regfile

Overview:
- Register file on the far side of the accumulator datapath.
- It consumes the accumulator's `regIn` write data and returns `reg_out` back to the accumulator's load mux.
- A second read port, `opB`, feeds the ALU operand.
- A built-in clear sequencer zeroes the array, one entry per cycle, on request.

Parameters:
- WIDTH, 8, data width of each register (must match the accumulator data path).
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries (4 by default); non-power-of-two depth is not supported.

Ports:
- clk  input  1  rising-edge clock
- CLB  input  1  reset: synchronous, active-high; clears array, outputs and FSM
- regIn  input  WIDTH  write data from the accumulator
- WrEn  input  1  write strobe
- WrAddr  input  ADDR_W  write address
- RdAddrA  input  ADDR_W  read address for reg_out
- RdAddrB  input  ADDR_W  read address for opB
- ClrReq  input  1  request a full-array clear sweep
- reg_out  output  WIDTH  registered read port A, to the accumulator
- opB  output  WIDTH  registered read port B, to the ALU
- ClrBusy  output  1  high while the sweep is in progress
- ClrDone  output  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (CLB=1 at a clk edge):
  - all DEPTH entries become 0;
  - reg_out=0, opB=0, ClrBusy=0, ClrDone=0;
  - FSM goes to CLR_IDLE and the sweep index to 0.
  - Reset has priority over every other input, including mid-sweep (the sweep is abandoned and ClrDone does not fire).
- Write:
  - In CLR_IDLE, WrEn=1 stores regIn into mem[WrAddr] at the edge.
  - WrEn while ClrBusy=1 is dropped with no effect; upstream must hold writes until ClrBusy=0.
- Read:
  - Both ports are registered, with 1-cycle latency: at each edge, reg_out<=mem[RdAddrA] and opB<=mem[RdAddrB].
  - The ports are independent; equal addresses are allowed.
  - Reads are never blocked, including during a sweep.
- Same-cycle read/write conflict: result depends on REGFILE_BYPASS_EN (see Optional Feature).
- Clear FSM states: CLR_IDLE, CLR_SWEEP, CLR_DONE.
  - CLR_IDLE: ClrReq=1 -> CLR_SWEEP with idx=0. A WrEn in the same cycle as ClrReq is still performed; the sweep then zeroes that entry.
  - CLR_SWEEP: ClrBusy=1. Each cycle mem[idx]<=0 and idx<=idx+1. When idx==DEPTH-1, go to CLR_DONE; the index wraps to 0.
  - CLR_DONE: lasts one cycle; ClrDone=1, ClrBusy=0; then -> CLR_IDLE.
  - ClrReq is ignored in CLR_SWEEP and CLR_DONE; it is not queued.
- Sweep length: exactly DEPTH cycles of ClrBusy, followed by one ClrDone cycle.
- Widths: no arithmetic on data. The address/index counter is ADDR_W bits and wraps naturally.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port whose address equals WrAddr while a write is accepted returns regIn in the same edge (write-first).
  - During CLR_SWEEP, a read of the entry being cleared returns 0.
- Undefined:
  - Read-first behaviour: the port returns the old mem contents.
  - The new value is visible on the next read.

Decomposition:
- Package regfile_pkg:
  - WIDTH and ADDR_W defaults;
  - clear FSM state enum {CLR_IDLE, CLR_SWEEP, CLR_DONE}.
- One sub-module, regfile_clr_seq, contains the sweep FSM and index counter.
  - It outputs ClrBusy, ClrDone, clr_we and clr_idx.
  - The top level holds the array, the write mux and the read registers.

Test Plan:
- Reset: preload mem[2]=8'hA5, assert CLB for 1 cycle -> reg_out=0, opB=0, ClrBusy=0; a following read of address 2 returns 8'h00.
- Write then read: WrEn=1, WrAddr=1, regIn=8'h3C; next cycle RdAddrA=1, RdAddrB=1 -> reg_out=opB=8'h3C one edge later.
- Conflict: mem[3]=8'h11; same cycle WrEn=1, WrAddr=3, regIn=8'h22, RdAddrA=3 -> reg_out=8'h22 with REGFILE_BYPASS_EN, 8'h11 without.
- Sweep timing, DEPTH=4:
  - preload entries with 8'hFF, pulse ClrReq -> ClrBusy high for 4 cycles, then ClrDone for exactly 1 cycle;
  - all entries then read 8'h00.
- Write during sweep: WrEn=1, WrAddr=3, regIn=8'h77 while ClrBusy=1 -> mem[3] reads 8'h00 after the sweep.
- Reset mid-sweep: CLB=1 at the 2nd sweep cycle -> ClrBusy=0 on the next cycle, ClrDone never pulses, all entries read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and clear-sequencer state type for the accumulator register file.
package regfile_pkg;

  localparam int REGFILE_WIDTH  = 8;
  localparam int REGFILE_ADDR_W = 2;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_SWEEP,
    CLR_DONE
  } clr_state_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: sweeps every register-file entry to zero, one per cycle, on request.
//   state     | meaning
//   CLR_IDLE  | waiting for ClrReq; writes allowed
//   CLR_SWEEP | clearing entry clr_idx this cycle; writes dropped
//   CLR_DONE  | one-cycle completion pulse
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic              ClrReq,
  output logic              ClrBusy,
  output logic              ClrDone,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  clr_state_t state;

  always_ff @(posedge clk) begin
    if (CLB) begin
      state   <= CLR_IDLE;
      clr_idx <= '0;
      ClrBusy <= 1'b0;
      ClrDone <= 1'b0;
    end else begin
      case (state)
        CLR_IDLE: begin
          ClrDone <= 1'b0;
          if (ClrReq) begin
            state   <= CLR_SWEEP;
            clr_idx <= '0;
            ClrBusy <= 1'b1;
          end
        end
        CLR_SWEEP: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == IDX_LAST) begin
            state   <= CLR_DONE;
            ClrBusy <= 1'b0;
            ClrDone <= 1'b1;
          end
        end
        CLR_DONE: begin
          state   <= CLR_IDLE;
          ClrDone <= 1'b0;
        end
        default: begin
          state   <= CLR_IDLE;
          clr_idx <= '0;
          ClrBusy <= 1'b0;
          ClrDone <= 1'b0;
        end
      endcase
    end
  end

  // ClrBusy is high exactly while the FSM sits in CLR_SWEEP.
  assign clr_we = ClrBusy;

endmodule

// File: rtl/acc_regfile.sv
// Accumulator register file: one write port, two registered read ports, built-in clear sweep.
// Optional REGFILE_BYPASS_EN makes reads write-first and returns 0 for the entry being cleared.
module acc_regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REGFILE_WIDTH,
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic [WIDTH-1:0]  regIn,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [ADDR_W-1:0] RdAddrA,
  input  logic [ADDR_W-1:0] RdAddrB,
  input  logic              ClrReq,
  output logic [WIDTH-1:0]  reg_out,
  output logic [WIDTH-1:0]  opB,
  output logic              ClrBusy,
  output logic              ClrDone
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_ok;
  logic [WIDTH-1:0]  rd_a;
  logic [WIDTH-1:0]  rd_b;

  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk     (clk),
    .CLB     (CLB),
    .ClrReq  (ClrReq),
    .ClrBusy (ClrBusy),
    .ClrDone (ClrDone),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign wr_ok = WrEn && !ClrBusy;

  always_ff @(posedge clk) begin
    if (CLB) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[WrAddr] <= regIn;
    end
  end

  always_comb begin
    rd_a = mem[RdAddrA];
    rd_b = mem[RdAddrB];
`ifdef REGFILE_BYPASS_EN
    if (clr_we && clr_idx == RdAddrA) rd_a = '0;
    if (clr_we && clr_idx == RdAddrB) rd_b = '0;
    if (wr_ok && WrAddr == RdAddrA) rd_a = regIn;
    if (wr_ok && WrAddr == RdAddrB) rd_b = regIn;
`endif
  end

  always_ff @(posedge clk) begin
    if (CLB) begin
      reg_out <= '0;
      opB     <= '0;
    end else begin
      reg_out <= rd_a;
      opB     <= rd_b;
    end
  end

endmodule
